// File: rtl/load_ext_pipe_pkg.sv
// Shared definitions for the load-extension pipe: access-size encoding and lane helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package load_ext_pipe_pkg;

  // Access size as carried on in_size.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  // Index of the top bit of the selected lane; also the sign bit when extending.
  function automatic int lane_msb(size_e sz);
    case (sz)
      SZ_BYTE: return 7;
      SZ_HALF: return 15;
      default: return 31;
    endcase
  endfunction

  // Byte accesses may sit at any offset. Halves need 2-byte alignment and words
  // need 4-byte alignment. The reserved encoding is always an error.
  function automatic logic access_err(size_e sz, logic [1:0] off_lo);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off_lo[0];
      SZ_WORD: return |off_lo;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_ext_pipe_if.sv
// Request/response bundle of the load-extension pipe.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the request side (in_*) and the result side (out_*).
//   master: requester and consumer (drives in_*, out_ready)
//   slave : the pipe (drives in_ready, out_valid, out_data, out_err)
interface load_ext_pipe_if #(
  parameter int WIDTH = 32,
  parameter int OFFW  = $clog2(WIDTH / 8)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_word;
  logic [OFFW-1:0]  in_off;
  logic [1:0]       in_size;
  logic             in_extop;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;

  modport master (
    output in_valid, in_word, in_off, in_size, in_extop, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_word, in_off, in_size, in_extop, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/load_ext_pipe_lane_ext.sv
// Combinational extender: widens a lane already shifted down to bit 0 into a full word.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is captured.
//   lane_i : lane data, the byte, half or word starts at bit 0
//   size_i : access size, which selects the lane top bit
//   ext_i  : 1 copies the lane top bit upward, 0 fills with zeros
//   data_o : extended result
module lane_ext
  import load_ext_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] lane_i,
  input  size_e            size_i,
  input  logic             ext_i,
  output logic [WIDTH-1:0] data_o
);

  localparam int IW = $clog2(WIDTH);

  logic [IW-1:0] msb;
  logic          fill;

  always_comb begin
    msb    = IW'(lane_msb(size_i));
    fill   = ext_i & lane_i[msb];
    data_o = '0;
    // Bits at or below the lane top bit pass through; bits above take the fill value.
    for (int i = 0; i < WIDTH; i++) begin
      data_o[i] = (i <= int'(msb)) ? lane_i[i] : fill;
    end
  end

endmodule

// File: rtl/load_ext_pipe.sv
// Load-data extension pipe: picks the byte, half or word lane and sign- or zero-extends it.
// Latency: 2 cycles from acceptance to out_valid; one result per cycle throughput.
// Backpressure: S2 holds while out_valid & !out_ready. S1 moves only into an empty or draining S2.
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset, clears both stages
//   flush : synchronous kill of both stages; in_ready is held low during flush
//   bus   : request (in_*) and result (out_*) handshakes, see load_ext_pipe_if
//           WIDTH and OFFW must match the parameters of the connected interface.
module load_ext_pipe
  import load_ext_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OFFW  = $clog2(WIDTH / 8)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  load_ext_pipe_if.slave bus
);

  // Stage 1: selected lane plus decode results.
  logic             s1_vld_q,  s1_vld_d;
  logic [WIDTH-1:0] s1_lane_q, s1_lane_d;
  size_e            s1_size_q, s1_size_d;
  logic             s1_ext_q,  s1_ext_d;
  logic             s1_err_q,  s1_err_d;

  // Stage 2: extended result, which drives the outputs directly.
  logic             s2_vld_q,  s2_vld_d;
  logic [WIDTH-1:0] s2_data_q, s2_data_d;
  logic             s2_err_q,  s2_err_d;

  logic             s2_adv;
  logic             accept;
  size_e            in_sz;
  logic [OFFW+2:0]  sh;
  logic [WIDTH-1:0] ext_data;

  // S2 can take a new entry when it is empty or its current result is being consumed.
  assign s2_adv = !s2_vld_q || bus.out_ready;

  // in_ready depends only on pipeline state, out_ready and flush. It never depends on in_valid.
  assign bus.in_ready = !flush && (!s1_vld_q || s2_adv);
  assign accept       = bus.in_valid && bus.in_ready;

  assign in_sz = size_e'(bus.in_size);
  assign sh    = {bus.in_off, 3'b000};

  lane_ext #(.WIDTH(WIDTH)) u_lane_ext (
    .lane_i (s1_lane_q),
    .size_i (s1_size_q),
    .ext_i  (s1_ext_q),
    .data_o (ext_data)
  );

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_lane_d = s1_lane_q;
    s1_size_d = s1_size_q;
    s1_ext_d  = s1_ext_q;
    s1_err_d  = s1_err_q;
    s2_vld_d  = s2_vld_q;
    s2_data_d = s2_data_q;
    s2_err_d  = s2_err_q;

    if (!s1_vld_q || s2_adv) begin
      s1_vld_d = accept;
      if (accept) begin
        s1_lane_d = bus.in_word >> sh;
        s1_size_d = in_sz;
        s1_ext_d  = bus.in_extop;
        s1_err_d  = access_err(in_sz, bus.in_off[1:0]);
      end
    end

    // An error entry drives zero data. An empty slot also reads back as zero.
    if (s2_adv) begin
      s2_vld_d  = s1_vld_q;
      s2_data_d = (s1_vld_q && !s1_err_q) ? ext_data : '0;
      s2_err_d  = s1_vld_q && s1_err_q;
    end

    if (flush) begin
      s1_vld_d  = 1'b0;
      s2_vld_d  = 1'b0;
      s2_data_d = '0;
      s2_err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_lane_q <= '0;
      s1_size_q <= SZ_BYTE;
      s1_ext_q  <= 1'b0;
      s1_err_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_data_q <= '0;
      s2_err_q  <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_lane_q <= s1_lane_d;
      s1_size_q <= s1_size_d;
      s1_ext_q  <= s1_ext_d;
      s1_err_q  <= s1_err_d;
      s2_vld_q  <= s2_vld_d;
      s2_data_q <= s2_data_d;
      s2_err_q  <= s2_err_d;
    end
  end

  assign bus.out_valid = s2_vld_q;
  assign bus.out_data  = s2_data_q;
  assign bus.out_err   = s2_err_q;

endmodule

// File: tb/tb_load_ext_pipe.sv
// Bench for load_ext_pipe: directed vectors plus a queue-based reference model of the extension rules.
// Latency: checks the 2-cycle result timing and the in_ready drop under stall.
// Backpressure: drives out_ready patterns, flush and a reset during traffic.
module tb_load_ext_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  load_ext_pipe_if #(.WIDTH(32)) bus ();

  load_ext_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int n_push = 0;
  int n_pop = 0;
  logic [32:0] exp_q[$];
  logic [32:0] out_log[$];
  logic        prev_stall = 1'b0;
  logic [32:0] prev_out = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model built from the access rules: {err, data}.
  function automatic logic [32:0] model(logic [31:0] w, logic [1:0] off, logic [1:0] sz, logic ext);
    int          bits;
    logic [31:0] v, mask;
    if (sz == 2'b11 || (sz == 2'b01 && off[0]) || (sz == 2'b10 && off != 2'b00))
      return {1'b1, 32'h0};
    bits = 8 << sz;
    v    = w >> (8 * off);
    mask = (bits == 32) ? 32'hFFFF_FFFF : ((32'h1 << bits) - 32'h1);
    v    = v & mask;
    if (ext && v[bits-1]) v = v | ~mask;
    return {1'b0, v};
  endfunction

  // Compare process. At each negedge the handshake signals show what the next rising edge will do.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
      chk("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
    end else begin
      if (prev_stall) begin
        chk("stall_hold_valid", {63'b0, bus.out_valid}, 64'd1);
        chk("stall_hold_data", {31'b0, bus.out_err, bus.out_data}, {31'b0, prev_out});
      end
      if (bus.out_valid) begin
        chk("out_has_pending", {63'b0, exp_q.size() > 0}, 64'd1);
        if (bus.out_ready && exp_q.size() > 0) begin
          chk("model_out", {31'b0, bus.out_err, bus.out_data}, {31'b0, exp_q.pop_front()});
          out_log.push_back({bus.out_err, bus.out_data});
          n_pop++;
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready && !flush;
      prev_out   = {bus.out_err, bus.out_data};
      if (flush) exp_q.delete();
      else if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.in_word, bus.in_off, bus.in_size, bus.in_extop));
        n_push++;
      end
    end
  end

  task automatic drive(input logic [31:0] w, input logic [1:0] off, input logic [1:0] sz, input logic ext);
    bus.in_valid = 1'b1;
    bus.in_word  = w;
    bus.in_off   = off;
    bus.in_size  = sz;
    bus.in_extop = ext;
  endtask

  // One request into an idle pipe with out_ready high. Checks the latency and the literal result.
  task automatic one(input string nm, input logic [31:0] w, input logic [1:0] off, input logic [1:0] sz,
                     input logic ext, input logic [31:0] exp_d, input logic exp_e);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drive(w, off, sz, ext);
    #1 chk({nm, "_in_ready"}, {63'b0, bus.in_ready}, 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk({nm, "_lat1"}, {63'b0, bus.out_valid}, 64'd0);
    @(posedge clk); #1;
    chk({nm, "_lat2"}, {63'b0, bus.out_valid}, 64'd1);
    chk({nm, "_data"}, {32'b0, bus.out_data}, {32'b0, exp_d});
    chk({nm, "_err"}, {63'b0, bus.out_err}, {63'b0, exp_e});
  endtask

  logic [31:0] sw[4];
  logic [1:0]  so[4];
  logic [1:0]  ss[4];
  logic        se[4];
  logic        irdy[12];
  int          base_pop;
  int          seen;

  initial begin
    bus.in_valid = 1'b0; bus.in_word = '0; bus.in_off = '0; bus.in_size = '0;
    bus.in_extop = 1'b0; bus.out_ready = 1'b1;

    // Reset state
    #1;
    chk("reset_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("reset_out_data", {32'b0, bus.out_data}, 64'd0);
    chk("reset_out_err", {63'b0, bus.out_err}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("reset_in_ready", {63'b0, bus.in_ready}, 64'd1);

    // Single-shot directed vectors: word 0x8081_7F80 holds bytes 80,7F,81,80 from offset 0 to 3.
    one("byte0_sx", 32'h8081_7F80, 2'd0, 2'b00, 1'b1, 32'hFFFF_FF80, 1'b0);
    one("byte0_zx", 32'h8081_7F80, 2'd0, 2'b00, 1'b0, 32'h0000_0080, 1'b0);
    one("half2_sx", 32'h8081_7F80, 2'd2, 2'b01, 1'b1, 32'hFFFF_8081, 1'b0);
    one("half3_err", 32'h8081_7F80, 2'd3, 2'b01, 1'b1, 32'h0000_0000, 1'b1);
    one("rsvd_err", 32'h8081_7F80, 2'd1, 2'b11, 1'b0, 32'h0000_0000, 1'b1);
    one("word0_zx", 32'h8081_7F80, 2'd0, 2'b10, 1'b0, 32'h8081_7F80, 1'b0);
    one("word0_sx", 32'h8081_7F80, 2'd0, 2'b10, 1'b1, 32'h8081_7F80, 1'b0);
    one("byte1_sx", 32'h8081_7F80, 2'd1, 2'b00, 1'b1, 32'h0000_007F, 1'b0);
    one("byte3_zx", 32'h8081_7F80, 2'd3, 2'b00, 1'b0, 32'h0000_0080, 1'b0);
    one("byte2_sx", 32'h8081_7F80, 2'd2, 2'b00, 1'b1, 32'hFFFF_FF81, 1'b0);
    one("half0_sx", 32'h8081_7F80, 2'd0, 2'b01, 1'b1, 32'h0000_7F80, 1'b0);
    one("word2_err", 32'h8081_7F80, 2'd2, 2'b10, 1'b0, 32'h0000_0000, 1'b1);
    one("half1_err", 32'h8081_7F80, 2'd1, 2'b01, 1'b0, 32'h0000_0000, 1'b1);

    // Four back-to-back requests while the consumer stalls for 3 cycles.
    sw[0] = 32'h8081_7F80; so[0] = 2'd0; ss[0] = 2'b00; se[0] = 1'b1;
    sw[1] = 32'h8081_7F80; so[1] = 2'd2; ss[1] = 2'b01; se[1] = 1'b1;
    sw[2] = 32'h1122_3344; so[2] = 2'd0; ss[2] = 2'b10; se[2] = 1'b0;
    sw[3] = 32'h8081_7F80; so[3] = 2'd3; ss[3] = 2'b01; se[3] = 1'b0;
    @(posedge clk); #1;
    out_log.delete();
    base_pop = n_pop;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      logic acc;
      if (seen < 4) drive(sw[seen], so[seen], ss[seen], se[seen]);
      else bus.in_valid = 1'b0;
      bus.out_ready = (c >= 3);
      @(negedge clk);
      irdy[c] = bus.in_ready;
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) seen++;
    end
    bus.in_valid = 1'b0;
    chk("b2b_in_ready_c0", {63'b0, irdy[0]}, 64'd1);
    chk("b2b_in_ready_c1", {63'b0, irdy[1]}, 64'd1);
    chk("b2b_in_ready_c2", {63'b0, irdy[2]}, 64'd0);
    chk("b2b_accepted", seen, 64'd4);
    chk("b2b_popped", n_pop - base_pop, 64'd4);
    chk("b2b_log_size", out_log.size(), 64'd4);
    if (out_log.size() == 4) begin
      chk("b2b_r0", {31'b0, out_log[0]}, {31'b0, 1'b0, 32'hFFFF_FF80});
      chk("b2b_r1", {31'b0, out_log[1]}, {31'b0, 1'b0, 32'hFFFF_8081});
      chk("b2b_r2", {31'b0, out_log[2]}, {31'b0, 1'b0, 32'h1122_3344});
      chk("b2b_r3", {31'b0, out_log[3]}, {31'b0, 1'b1, 32'h0000_0000});
    end

    // Flush with both stages full and a request pending.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    drive(32'hA5A5_0001, 2'd0, 2'b00, 1'b1);
    @(posedge clk); #1;
    drive(32'hA5A5_0002, 2'd0, 2'b10, 1'b0);
    @(posedge clk); #1;
    chk("flush_pre_valid", {63'b0, bus.out_valid}, 64'd1);
    drive(32'hA5A5_0003, 2'd0, 2'b10, 1'b0);
    flush = 1'b1;
    #1 chk("flush_in_ready", {63'b0, bus.in_ready}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("flush_out_valid", {63'b0, bus.out_valid}, 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("flush_no_late_out", {63'b0, bus.out_valid}, 64'd0);
    end

    // Reset pulse during traffic.
    @(posedge clk); #1;
    drive(32'h0000_00FF, 2'd0, 2'b00, 1'b1);
    @(posedge clk); #1;
    drive(32'h0000_FF00, 2'd1, 2'b00, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("rst_mid_pre_valid", {63'b0, bus.out_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("rst_mid_out_data", {32'b0, bus.out_data}, 64'd0);
    chk("rst_mid_out_err", {63'b0, bus.out_err}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1 chk("rst_mid_in_ready", {63'b0, bus.in_ready}, 64'd1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_mid_no_out", {63'b0, bus.out_valid}, 64'd0);
    end

    // Traffic after reset still produces results.
    one("post_rst_byte", 32'h8081_7F80, 2'd0, 2'b00, 1'b1, 32'hFFFF_FF80, 1'b0);
    @(posedge clk); #1;
    chk("final_queue_empty", exp_q.size(), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_ext_pipe.md
LOAD_EXT_PIPE -- requirements
Module: load_ext_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data-path width in bits (power of two, >=32).
REQ-002 SHALL have parameter OFFW, default $clog2(WIDTH/8), meaning byte-offset width.
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous kill of all in-flight entries.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  request accepted when in_valid&in_ready.
REQ-008 SHALL have port in_word  input  WIDTH  raw memory word.
REQ-009 SHALL have port in_off  input  OFFW  byte offset of access within in_word.
REQ-010 SHALL have port in_size  input  2  00 byte, 01 half, 10 word(32b), 11 reserved.
REQ-011 SHALL have port in_extop  input  1  1 sign-extend, 0 zero-extend.
REQ-012 SHALL have port out_valid  output  1  result present.
REQ-013 SHALL have port out_ready  input  1  consumer accepts when out_valid&out_ready.
REQ-014 SHALL have port out_data  output  WIDTH  extended result.
REQ-015 SHALL have port out_err  output  1  misaligned or reserved-size access.

Function
REQ-016 SHALL be a two-stage pipeline: S1 registers the selected lane (byte/half/word shifted to bit 0) plus size/extop/err; S2 registers the extended value.
REQ-017 SHALL produce out_valid exactly 2 cycles after acceptance when out_ready is held 1 (one result per cycle throughput).
REQ-018 SHALL extend byte from bit 7, half from bit 15, word from bit 31 when in_extop=1; zero-fill above the lane when in_extop=0; word with WIDTH=32 passes unchanged.
REQ-019 SHALL flag err for: half with in_off[0]=1; word with in_off[1:0]!=0; size 11; err entries output out_data=0 with out_err=1.
REQ-020 SHALL stall: S2 holds when out_valid&!out_ready; S1 advances only if S2 empty or draining; in_ready = !S1_valid | S1 advancing (no combinational path in_valid->in_ready).
REQ-021 SHALL keep out_data/out_err stable while out_valid&!out_ready.
REQ-022 SHALL, on flush, clear S1 and S2 valid next edge and ignore a same-cycle in_valid (in_ready=0 during flush).
REQ-023 SHALL accept a new request in the same cycle an output is consumed when the pipeline is full (no bubble).
REQ-024 SHALL ignore in_off bits outside the lane alignment only for byte accesses (all offsets legal).

Reset
REQ-025 SHALL, with rst_n=0, asynchronously clear S1/S2 valid, out_valid=0, out_data=0, out_err=0; in_ready=1 after reset release.
REQ-026 SHALL discard in-flight entries on reset mid-operation; no output after release until a new acceptance.

Structure
REQ-027 SHALL take size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD) from a shared package, also used by the decoder.
REQ-028 SHALL instantiate one sub-module lane_ext (combinational size/extop extender) used in S2.

Verification
REQ-029 SHALL cover: word 0x8081_7F80, off 0, byte, extop=1 -> 0xFFFF_FF80 two cycles later; extop=0 -> 0x0000_0080.
REQ-030 SHALL cover: word 0x8081_7F80, off 2, half, extop=1 -> 0xFFFF_8081; off 3 half -> out_err=1, out_data=0.
REQ-031 SHALL cover: size=11 any offset -> out_err=1; word off 0 -> 0x8081_7F80 unchanged.
REQ-032 SHALL cover: 4 back-to-back requests with out_ready=0 for 3 cycles -> in_ready drops after 2 accepted, results emerge in order, none lost or duplicated.
REQ-033 SHALL cover: flush with both stages full and in_valid=1 -> out_valid=0 next cycle, flushed request not accepted.
REQ-034 SHALL cover: rst_n low for one cycle mid-stream -> out_valid=0 immediately, in_ready=1 after release.
